register_16bit: RTL and testbench



---
 rtl/register_16bit_pkg.sv | 8 +
 rtl/register_16bit.sv | 32 +++
 tb/tb_register_16bit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/register_16bit_pkg.sv
// Shared constants for the 16-bit holding register.
package register_16bit_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

endpackage : register_16bit_pkg

// File: rtl/register_16bit.sv
// Single-clock D register: loads d on every rising edge, synchronous clear wins over data.
module register_16bit
  import register_16bit_pkg::*;
#(
  parameter int unsigned        WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = d;
  end

  // Storage flops; rst is only looked at on the edge, so q has no path from d or rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : register_16bit

// File: tb/tb_register_16bit.sv
// Self-checking bench for register_16bit: vector table, scoreboard queue, corner sequences.
module tb_register_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] d;
  logic [15:0] q;

  register_16bit dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [9];
  logic [15:0] exp_q [$];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic check(input string name, input logic [15:0] exp);
    n_cmp++;
    if (q !== exp) begin
      n_mis++;
      $display("FAIL %s: q=%h required=%h at %0t", name, q, exp, $time);
    end
  endtask

  // Drive on the falling edge, queue the expectation, compare 1 ns after the next rising edge.
  task automatic step(input logic r, input logic [15:0] dv, input logic [15:0] exp,
                      input string name);
    logic [15:0] e;
    @(negedge clk);
    rst = r;
    d   = dv;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r;
    logic [15:0] dv;

    vecs[0] = '{rst: 1'b1, d: 16'hA5A5, exp: 16'h0000};
    vecs[1] = '{rst: 1'b0, d: 16'h1234, exp: 16'h1234};
    vecs[2] = '{rst: 1'b0, d: 16'hFFFF, exp: 16'hFFFF};
    vecs[3] = '{rst: 1'b0, d: 16'h0000, exp: 16'h0000};
    vecs[4] = '{rst: 1'b0, d: 16'h00FF, exp: 16'h00FF};
    vecs[5] = '{rst: 1'b1, d: 16'h1111, exp: 16'h0000};
    vecs[6] = '{rst: 1'b0, d: 16'h8001, exp: 16'h8001};
    vecs[7] = '{rst: 1'b0, d: 16'hFFFF, exp: 16'hFFFF};
    vecs[8] = '{rst: 1'b1, d: 16'hFFFF, exp: 16'h0000};

    rst = 1'b1;
    d   = 16'h0000;

    // Reset state (the first edge defines q)
    step(1'b1, 16'h0000, 16'h0000, "reset_state");

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Sync-only reset: rst raised mid-cycle must not touch q before the edge
    step(1'b0, 16'hBEEF, 16'hBEEF, "load_beef");
    #2;
    rst = 1'b1;
    #1;
    check("async_assert_hold", 16'hBEEF);
    @(negedge clk);
    #1;
    check("async_assert_hold_neg", 16'hBEEF);
    @(posedge clk);
    #1;
    check("sync_assert_clear", 16'h0000);

    // Deasserting rst between edges has no effect until the next edge
    #2;
    rst = 1'b0;
    d   = 16'h7E57;
    #1;
    check("async_deassert_hold", 16'h0000);
    @(posedge clk);
    #1;
    check("deassert_load", 16'h7E57);

    // Data hold: d disturbed only between edges, restored before each edge
    step(1'b0, 16'h5A5A, 16'h5A5A, "hold_load");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d = 16'($urandom) ^ 16'h5A5A | 16'h0001;
      #1;
      check($sformatf("hold_mid%0d", k), 16'h5A5A);
      #2;
      d = 16'h5A5A;
      @(posedge clk);
      #1;
      check($sformatf("hold_edge%0d", k), 16'h5A5A);
    end

    // Randomized run with a reference model
    for (int j = 0; j < 20; j++) begin
      r  = 1'($urandom_range(0, 1));
      dv = 16'($urandom);
      step(r, dv, r ? 16'h0000 : dv, $sformatf("rand%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_register_16bit
